// File: rtl/misr_output_compactor.sv
// Folds a wide data word into a SIG_WIDTH-bit Galois MISR and publishes the
// signature after every WINDOW accepted beats, then reloads the seed.
module misr_output_compactor #(
   parameter int                    DATA_WIDTH = 64,
   parameter int                    SIG_WIDTH  = 32,
   parameter logic [SIG_WIDTH-1:0]  POLY       = SIG_WIDTH'(32'h04C11DB7),
   parameter logic [SIG_WIDTH-1:0]  SEED       = '0,
   parameter int                    WINDOW     = 4,
   localparam int                   CNT_W      = $clog2(WINDOW + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic [SIG_WIDTH-1:0]  signature,
   output logic                  signature_valid,
   output logic [CNT_W-1:0]      beat_count,
   output logic                  sig_parity
);

   localparam int NCHUNK = (DATA_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int PAD_W  = NCHUNK * SIG_WIDTH;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

   typedef enum logic {ACCUM, PUBLISH} state_t;

   state_t               state, state_nx;
   logic [SIG_WIDTH-1:0] misr;
   logic [SIG_WIDTH-1:0] misr_step;
   logic                 last_beat;

   // Zero-pad to whole chunks, then XOR all chunks together.
   function automatic logic [SIG_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] d);
      logic [PAD_W-1:0]     pad;
      logic [SIG_WIDTH-1:0] acc;
      pad                   = '0;
      pad[DATA_WIDTH-1:0]   = d;
      acc                   = '0;
      for (int i = 0; i < NCHUNK; i++)
         acc ^= pad[i*SIG_WIDTH +: SIG_WIDTH];
      return acc;
   endfunction

   function automatic logic [SIG_WIDTH-1:0] step(input logic [SIG_WIDTH-1:0] m,
                                                  input logic [SIG_WIDTH-1:0] f);
      return {m[SIG_WIDTH-2:0], 1'b0} ^ (m[SIG_WIDTH-1] ? POLY : '0) ^ f;
   endfunction

   always_comb begin
      misr_step       = step(misr, fold(data_in));
      last_beat       = data_valid && (beat_count == LAST_BEAT);
      state_nx        = state;
      signature_valid = 1'b0;
      case (state)
         ACCUM: begin
            if (last_beat) state_nx = PUBLISH;
         end
         PUBLISH: begin
            signature_valid = 1'b1;
            // With WINDOW=1 a valid beat here publishes again back to back.
            state_nx = last_beat ? PUBLISH : ACCUM;
         end
         default: state_nx = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ACCUM;
         misr       <= SEED;
         beat_count <= '0;
         signature  <= '0;
         sig_parity <= 1'b0;
      end else begin
         state <= state_nx;
         if (last_beat) begin
            misr       <= SEED;
            beat_count <= '0;
            signature  <= misr_step;
            sig_parity <= ^misr_step;
         end else if (data_valid) begin
            misr       <= misr_step;
            beat_count <= beat_count + 1'b1;
         end
      end
   end

endmodule
